// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity-type codes, payload
// struct and the parity helper used by both the transmit and receive halves.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_START  = 3'd1;
  localparam logic [ST_W-1:0] S_DATA   = 3'd2;
  localparam logic [ST_W-1:0] S_PARITY = 3'd3;
  localparam logic [ST_W-1:0] S_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_MARK = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  // Byte plus status as presented on the receive interface
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity_err;
    logic              frame_err;
  } rx_word_t;

  function automatic logic uart_parity(input logic [DATA_W-1:0] data,
                                       input logic [1:0]        ptype);
    logic p;
    case (ptype)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the serial line plus falling-edge detect on the
// synchronized value.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Idle-high line: flops reset to 1 so reset release never looks like a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign fall_c  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional parity, valid/ready byte output
// with parity/framing/overrun status. Define UART_RX_MAJORITY_EN for 3-tap voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DIV_W-1:0]  baud_divisor,
  input  logic [1:0]        i_parity_type,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  logic rx_s;
  logic fall_c;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_sync (rx_s),
    .fall_c  (fall_c)
  );

  logic [ST_W-1:0]   state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        par_q, par_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        idx_q, idx_d;
  logic              perr_q, perr_d;
  rx_word_t          out_q, out_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic [DIV_W-1:0]  half_c;
  logic [DIV_W-1:0]  restart_c;
  logic              start_tick_c;
  logic              bit_tick_c;
  logic              samp_c;

  assign half_c = div_q >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // Vote is resolved one clock after the centre tap, so the counter restarts
  // at 1 to keep count 0 aligned with the start-bit centre.
  always_comb begin
    hist_d       = {hist_q[0], rx_s};
    samp_c       = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    start_tick_c = (cnt_q == DIV_W'(half_c + 1'b1));
    bit_tick_c   = (cnt_q == '0);
    restart_c    = DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end
`else
  always_comb begin
    samp_c       = rx_s;
    start_tick_c = (cnt_q == half_c);
    bit_tick_c   = (cnt_q == DIV_W'(div_q - 1'b1));
    restart_c    = '0;
  end
`endif

  // Next-state, datapath and output-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == DIV_W'(div_q - 1'b1)) ? '0 : DIV_W'(cnt_q + 1'b1);
    div_d   = div_q;
    par_d   = par_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    perr_d  = perr_q;
    out_d   = out_q;
    valid_d = valid_q & ~rx_ready;
    ovr_d   = ovr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_c) begin
          state_d = S_START;
          div_d   = baud_divisor;
          par_d   = i_parity_type;
          perr_d  = 1'b0;
        end
      end

      S_START: begin
        if (start_tick_c) begin
          if (!samp_c) begin
            state_d = S_DATA;
            cnt_d   = restart_c;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (bit_tick_c) begin
          shreg_d = {samp_c, shreg_q[DATA_W-1:1]};
          idx_d   = 3'(idx_q + 3'd1);
          if (idx_q == 3'd7) begin
            state_d = (par_q == PAR_NONE) ? S_STOP : S_PARITY;
          end
        end
      end

      S_PARITY: begin
        if (bit_tick_c) begin
          perr_d  = (samp_c != uart_parity(shreg_q, par_q));
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_tick_c) begin
          state_d = S_IDLE;
          // A byte accepted this cycle frees the holding register for the new one
          if (!valid_q || rx_ready) begin
            out_d.data       = shreg_q;
            out_d.parity_err = perr_q;
            out_d.frame_err  = ~samp_c;
            valid_d          = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      par_q   <= PAR_NONE;
      shreg_q <= '0;
      idx_q   <= '0;
      perr_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      par_q   <= par_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      perr_q  <= perr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data    = out_q.data;
  assign parity_err = out_q.parity_err;
  assign frame_err  = out_q.frame_err;
  assign rx_valid   = valid_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART: recovers 8-bit frames from the asynchronous serial line and presents them on a valid/ready byte interface. Sits directly downstream of the serial pin, or of `uart_tx` in loopback. It uses the same `baud_divisor` value (clocks per bit) and the same `i_parity_type` encoding as the transmitter, so one register set configures both directions. It samples at mid-bit and reports parity, framing and overrun status with each byte.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `rx`; legal range 2–3.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input; idles high.
- `baud_divisor`  in  16  clocks per bit; legal minimum 8. Sampled only in IDLE.
- `i_parity_type`  in  2  00 none, 01 even (parity = ^data), 11 odd (parity = ~^data), 10 mark (parity = 1). Sampled only in IDLE.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch on the held byte; qualified by `rx_valid`.
- `frame_err`  out  1  stop bit sampled low on the held byte; qualified by `rx_valid`.
- `overrun`  out  1  sticky flag, set when a frame completes while `rx_valid`=1. Cleared by reset only.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through `SYNC_STAGES` flops. The falling-edge detect acts on the synchronized value. All other logic uses only the synchronized value.
- A 16-bit bit counter runs 0 .. `baud_divisor`-1, then wraps to 0. HALF = `baud_divisor`>>1. The sample point is count == HALF.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, clear the counter and go to START. Latch the divisor and parity type.
- START: at HALF, if the line is low, restart the counter (count 0 = start-bit centre) and go to DATA. If the line is high, treat it as a glitch and return to IDLE.
- Bit timing from here: each later sample fires at counter wrap, i.e. one full bit after the previous centre.
- DATA: sample 8 bits LSB first into a shift register. After bit 7, go to PARITY if the type is not 00; otherwise go to STOP.
- PARITY: sample one bit and compare it with the expected parity computed from the shifted data. Set the internal parity error on mismatch.
- STOP: sample one bit; `frame_err` = sample==0. Then return to IDLE in the same cycle as the sample. No wait for a full stop bit.
- Output register update at the STOP sample:
  - If `rx_valid`=0: load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`.
  - If `rx_valid`=1: keep the old byte and flags, discard the new frame, and set `overrun`.
- Handshake: `rx_valid` clears on the cycle after `rx_valid && rx_ready`. If the STOP sample coincides with acceptance, the new byte loads and `rx_valid` stays 1. This case is not an overrun.
- Line held low (break): framing error reported once. IDLE then requires a new falling edge, so a stuck-low line does not retrigger.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is discarded.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, counter 0, synchronizer flops 1.
- Sample latency: `SYNC_STAGES` clocks from a pin transition to the internal view.
- `rx_valid` rises 1 clock after the STOP sample cycle.
- Frame length in clocks: (1 + 8 + P + 0.5) × `baud_divisor`, where P = 1 if parity is enabled, else 0.
- Divisor or parity changes while busy have no effect until the next IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample is the majority of the synchronized line at counts HALF-1, HALF and HALF+1. START glitch rejection uses the majority value.
- Not defined: single sample at HALF.
- Both builds must meet the same test plan on clean input.

## Structure
- Shared package `uart_pkg`:
  - state encodings (IDLE=0 … STOP=4), shared with `uart_tx`
  - parity-type constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_MARK=2'b10, PAR_ODD=2'b11
  - a `uart_parity(data, type)` function used by both directions
- One sub-module: `uart_rx_sync` (parameterised synchronizer plus falling-edge detect).
- All other logic lives in `uart_rx`.

## Test plan
1. Divisor 16, no parity, `rx_ready`=1. Send 0x55 with 1 stop bit → `rx_data`=0x55 with a 1-cycle `rx_valid`; `parity_err`=0, `frame_err`=0.
2. Even parity, send 0xA7 with parity bit 1 → byte 0xA7 with `parity_err`=0. Repeat with parity bit 0 → `parity_err`=1. Odd type with 0xA7 and parity bit 0 → `parity_err`=0.
3. Stop bit driven low for 0x3C → `rx_data`=0x3C, `frame_err`=1. Line then held low for 40 bit times → no further `rx_valid`.
4. `rx_ready`=0. Send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun`=1. Assert `rx_ready` → `rx_valid` drops. A third frame 0x33 is received normally while `overrun` stays 1.
5. Low pulse of 3 clocks on an idle line (divisor 16) → START aborts to IDLE with no `rx_valid`. With `UART_RX_MAJORITY_EN`, a 1-clock high glitch at HALF inside bit 3 of 0x00 → byte still 0x00.
6. Assert `rst` during DATA of a frame, release, then send 0x81 → outputs at reset values during reset, partial frame discarded, 0x81 received correctly.
